// File: rtl/wb_scoreboard.sv
// wb_scoreboard
//
// Register scoreboard plus a two-entry writeback result queue.
//
// The decoder reserves a destination register through the issue port. The
// register is then reported busy to the hazard queries until its result has
// been written back. The ALU and LSU offer results through valid/ready
// handshakes, and the LSU always has priority. Accepted results pass through
// a 2-deep FIFO and are written to the register file one per cycle, unless
// wb_stall freezes the drain.
//
// Ports
//   clk, rst_n                  clock; asynchronous active-low reset
//   issue_valid, issue_rd       reservation request for a destination register
//   issue_ready                 reservation accepted (no WAW hazard)
//   rs1, rs2                    source register hazard queries
//   rs1_busy, rs2_busy          queried register has a pending write
//   alu_valid/rd/data, alu_ready  ALU result handshake
//   lsu_valid/rd/data, lsu_ready  LSU result handshake
//   wb_stall                    hold regfile writes (results still enqueue)
//   rf_wen, rf_waddr, rf_wdata  registered regfile write port
//   wb_pending                  result FIFO occupancy, 0..2
module wb_scoreboard #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ready,

    input  logic [4:0]      rs1,
    input  logic [4:0]      rs2,
    output logic            rs1_busy,
    output logic            rs2_busy,

    input  logic            alu_valid,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    output logic            alu_ready,

    input  logic            lsu_valid,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    output logic            lsu_ready,

    input  logic            wb_stall,

    output logic            rf_wen,
    output logic [4:0]      rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic [1:0]      wb_pending
);

    // Scoreboard
    logic [31:0] busy_q, busy_d;

    // Result FIFO storage and pointers
    logic [1:0][4:0]      fifo_rd_q, fifo_rd_d;
    logic [1:0][XLEN-1:0] fifo_data_q, fifo_data_d;
    logic                 wptr_q, wptr_d;
    logic                 rptr_q, rptr_d;
    logic [1:0]           count_q, count_d;

    // Registered regfile write port
    logic            rf_wen_q, rf_wen_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

    // Handshake and queue control
    logic            fifo_full;
    logic            fifo_empty;
    logic            lsu_fire;
    logic            alu_fire;
    logic            issue_fire;
    logic            enq;
    logic            deq;
    logic [4:0]      enq_rd;
    logic [XLEN-1:0] enq_data;

    assign fifo_full  = (count_q == 2'd2);
    assign fifo_empty = (count_q == 2'd0);

    // Readiness depends only on fullness. A dequeue in the same cycle does
    // not open a slot early.
    assign lsu_ready = ~fifo_full;
    assign alu_ready = ~fifo_full & ~lsu_valid;

    assign lsu_fire = lsu_valid & lsu_ready;
    assign alu_fire = alu_valid & alu_ready;

    // At most one of the two fires, because alu_ready excludes lsu_valid.
    assign enq_rd   = lsu_fire ? lsu_rd   : alu_rd;
    assign enq_data = lsu_fire ? lsu_data : alu_data;

    // A result for x0 completes its handshake but is dropped.
    assign enq = (lsu_fire | alu_fire) & (enq_rd != 5'd0);
    assign deq = ~fifo_empty & ~wb_stall;

    assign issue_ready = (issue_rd == 5'd0) | ~busy_q[issue_rd];
    assign issue_fire  = issue_valid & issue_ready & (issue_rd != 5'd0);

    assign rs1_busy = busy_q[rs1];
    assign rs2_busy = busy_q[rs2];

    assign rf_wen     = rf_wen_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;
    assign wb_pending = count_q;

    always_comb begin
        busy_d      = busy_q;
        fifo_rd_d   = fifo_rd_q;
        fifo_data_d = fifo_data_q;
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        count_d     = count_q;
        rf_wen_d    = 1'b0;
        rf_waddr_d  = rf_waddr_q;
        rf_wdata_d  = rf_wdata_q;

        if (enq) begin
            fifo_rd_d[wptr_q]   = enq_rd;
            fifo_data_d[wptr_q] = enq_data;
            wptr_d              = ~wptr_q;
        end

        if (deq) begin
            rf_wen_d   = 1'b1;
            rf_waddr_d = fifo_rd_q[rptr_q];
            rf_wdata_d = fifo_data_q[rptr_q];
            rptr_d     = ~rptr_q;
        end

        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // The clear is applied before the set, so a reservation made on the
        // same edge as a writeback to that register stays busy.
        if (rf_wen_q) begin
            busy_d[rf_waddr_q] = 1'b0;
        end
        if (issue_fire) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q      <= '0;
            fifo_rd_q   <= '0;
            fifo_data_q <= '0;
            wptr_q      <= 1'b0;
            rptr_q      <= 1'b0;
            count_q     <= '0;
            rf_wen_q    <= 1'b0;
            rf_waddr_q  <= '0;
            rf_wdata_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            fifo_rd_q   <= fifo_rd_d;
            fifo_data_q <= fifo_data_d;
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            count_q     <= count_d;
            rf_wen_q    <= rf_wen_d;
            rf_waddr_q  <= rf_waddr_d;
            rf_wdata_q  <= rf_wdata_d;
        end
    end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios plus randomized
// traffic checked against a queue-based behavioural model.
module tb_wb_scoreboard;

    localparam int XLEN = 32;
    localparam int RW   = 1 + 5 + XLEN + 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b1;
    logic            issue_valid;
    logic [4:0]      issue_rd;
    logic            issue_ready;
    logic [4:0]      rs1, rs2;
    logic            rs1_busy, rs2_busy;
    logic            alu_valid;
    logic [4:0]      alu_rd;
    logic [XLEN-1:0] alu_data;
    logic            alu_ready;
    logic            lsu_valid;
    logic [4:0]      lsu_rd;
    logic [XLEN-1:0] lsu_data;
    logic            lsu_ready;
    logic            wb_stall;
    logic            rf_wen;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic [1:0]      wb_pending;

    wb_scoreboard #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ready (issue_ready),
        .rs1         (rs1),
        .rs2         (rs2),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .alu_valid   (alu_valid),
        .alu_rd      (alu_rd),
        .alu_data    (alu_data),
        .alu_ready   (alu_ready),
        .lsu_valid   (lsu_valid),
        .lsu_rd      (lsu_rd),
        .lsu_data    (lsu_data),
        .lsu_ready   (lsu_ready),
        .wb_stall    (wb_stall),
        .rf_wen      (rf_wen),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .wb_pending  (wb_pending)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    // Behavioural model: a set of reserved registers, a queue of accepted
    // results, and the last regfile write.
    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
    } res_t;

    logic [31:0]     m_busy;
    res_t            m_q[$];
    logic            m_wen;
    logic [4:0]      m_waddr;
    logic [XLEN-1:0] m_wdata;

    function automatic void model_reset();
        m_busy  = '0;
        m_q.delete();
        m_wen   = 1'b0;
        m_waddr = '0;
        m_wdata = '0;
    endfunction

    function automatic void model_edge();
        res_t acc;
        bit   have;
        bit   full;
        bit   can_issue;
        if (!rst_n) begin
            model_reset();
            return;
        end
        full = (m_q.size() == 2);
        have = 0;
        acc  = '0;
        if (lsu_valid && !full) begin
            acc.rd = lsu_rd; acc.data = lsu_data; have = 1;
        end else if (alu_valid && !full) begin
            acc.rd = alu_rd; acc.data = alu_data; have = 1;
        end
        can_issue = issue_valid && (issue_rd != 0) && !m_busy[issue_rd];
        if (m_wen) m_busy[m_waddr] = 1'b0;
        if (can_issue) m_busy[issue_rd] = 1'b1;
        if (m_q.size() > 0 && !wb_stall) begin
            m_wen   = 1'b1;
            m_waddr = m_q[0].rd;
            m_wdata = m_q[0].data;
            void'(m_q.pop_front());
        end else begin
            m_wen = 1'b0;
        end
        if (have && acc.rd != 0) m_q.push_back(acc);
    endfunction

    task automatic idle();
        issue_valid = 0; issue_rd = 0; rs1 = 0; rs2 = 0;
        alu_valid = 0; alu_rd = 0; alu_data = '0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = '0;
        wb_stall = 0;
    endtask

    // One clock: advance the model on the edge, return at the falling edge.
    task automatic clk_cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle();
        #2 rst_n = 0;
        model_reset();
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata, wb_pending, rs1_busy} !== '0)
            $display("FAIL reset_outputs: got wen=%0b waddr=%0d wdata=%0h pend=%0d busy=%0b expected all 0",
                     rf_wen, rf_waddr, rf_wdata, wb_pending, rs1_busy);
        else n_pass++;
        alu_valid = 1; alu_rd = 5'd6; alu_data = 32'hCAFE0001;
        #1;
        n_total++;
        if ({alu_ready, lsu_ready} !== 2'b11)
            $display("FAIL reset_ready: got alu=%0b lsu=%0b expected 1 1", alu_ready, lsu_ready);
        else n_pass++;
        clk_cycle();
        clk_cycle();
        #1;
        n_total++;
        if ({wb_pending, rf_wen} !== 3'b000)
            $display("FAIL reset_no_transfer: got pend=%0d wen=%0b expected 0 0", wb_pending, rf_wen);
        else n_pass++;
        idle();
        rst_n = 1;
        clk_cycle();
        #1;
        n_total++;
        if ({wb_pending, rf_wen} !== 3'b000)
            $display("FAIL reset_release: got pend=%0d wen=%0b expected 0 0", wb_pending, rf_wen);
        else n_pass++;
    endtask

    task automatic test_basic();
        idle();
        issue_valid = 1; issue_rd = 5'd5; rs1 = 5'd5;
        clk_cycle();
        issue_valid = 0;
        #1;
        n_total++;
        if (rs1_busy !== 1'b1) $display("FAIL basic_reserve: rs1_busy=%0b expected 1", rs1_busy);
        else n_pass++;
        alu_valid = 1; alu_rd = 5'd5; alu_data = 32'hDEADBEEF;
        #1;
        n_total++;
        if (alu_ready !== 1'b1) $display("FAIL basic_alu_ready: got %0b expected 1", alu_ready);
        else n_pass++;
        clk_cycle();                       // edge N: accepted
        alu_valid = 0;
        #1;
        n_total++;
        if ({rf_wen, wb_pending, rs1_busy} !== {1'b0, 2'd1, 1'b1})
            $display("FAIL basic_after_accept: got wen=%0b pend=%0d busy=%0b expected 0 1 1",
                     rf_wen, wb_pending, rs1_busy);
        else n_pass++;
        clk_cycle();                       // edge N+1: write port loaded
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata, wb_pending, rs1_busy} !== {1'b1, 5'd5, 32'hDEADBEEF, 2'd0, 1'b1})
            $display("FAIL basic_write: got wen=%0b waddr=%0d wdata=%0h pend=%0d busy=%0b expected 1 5 deadbeef 0 1",
                     rf_wen, rf_waddr, rf_wdata, wb_pending, rs1_busy);
        else n_pass++;
        clk_cycle();                       // edge N+2: busy cleared
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata, rs1_busy} !== {1'b0, 5'd5, 32'hDEADBEEF, 1'b0})
            $display("FAIL basic_clear: got wen=%0b waddr=%0d wdata=%0h busy=%0b expected 0 5 deadbeef 0",
                     rf_wen, rf_waddr, rf_wdata, rs1_busy);
        else n_pass++;
    endtask

    task automatic test_priority();
        idle();
        lsu_valid = 1; lsu_rd = 5'd4; lsu_data = 32'h22;
        alu_valid = 1; alu_rd = 5'd3; alu_data = 32'h11;
        #1;
        n_total++;
        if ({lsu_ready, alu_ready} !== 2'b10)
            $display("FAIL prio_ready: got lsu=%0b alu=%0b expected 1 0", lsu_ready, alu_ready);
        else n_pass++;
        clk_cycle();
        lsu_valid = 0;
        #1;
        n_total++;
        if ({alu_ready, wb_pending} !== {1'b1, 2'd1})
            $display("FAIL prio_alu_next: got alu=%0b pend=%0d expected 1 1", alu_ready, wb_pending);
        else n_pass++;
        clk_cycle();
        alu_valid = 0;
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'h22})
            $display("FAIL prio_first_write: got wen=%0b waddr=%0d wdata=%0h expected 1 4 22", rf_wen, rf_waddr, rf_wdata);
        else n_pass++;
        clk_cycle();
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'h11})
            $display("FAIL prio_second_write: got wen=%0b waddr=%0d wdata=%0h expected 1 3 11", rf_wen, rf_waddr, rf_wdata);
        else n_pass++;
        clk_cycle();
        #1;
        n_total++;
        if ({rf_wen, wb_pending} !== 3'b000)
            $display("FAIL prio_drained: got wen=%0b pend=%0d expected 0 0", rf_wen, wb_pending);
        else n_pass++;
    endtask

    task automatic test_stall();
        logic [XLEN-1:0] d0, d1, d2;
        d0 = $urandom; d1 = $urandom; d2 = $urandom;
        idle();
        wb_stall = 1;
        alu_valid = 1; alu_rd = 5'd10; alu_data = d0;
        clk_cycle();
        alu_rd = 5'd11; alu_data = d1;
        clk_cycle();
        alu_rd = 5'd12; alu_data = d2;
        #1;
        n_total++;
        if ({wb_pending, alu_ready, lsu_ready, rf_wen} !== {2'd2, 1'b0, 1'b0, 1'b0})
            $display("FAIL stall_full: got pend=%0d alu=%0b lsu=%0b wen=%0b expected 2 0 0 0",
                     wb_pending, alu_ready, lsu_ready, rf_wen);
        else n_pass++;
        clk_cycle();
        #1;
        n_total++;
        if ({wb_pending, rf_wen} !== {2'd2, 1'b0})
            $display("FAIL stall_hold: got pend=%0d wen=%0b expected 2 0", wb_pending, rf_wen);
        else n_pass++;
        wb_stall = 0;
        clk_cycle();
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata, wb_pending, alu_ready} !== {1'b1, 5'd10, d0, 2'd1, 1'b1})
            $display("FAIL stall_write0: got wen=%0b waddr=%0d wdata=%0h pend=%0d alu=%0b expected 1 10 %0h 1 1",
                     rf_wen, rf_waddr, rf_wdata, wb_pending, alu_ready, d0);
        else n_pass++;
        clk_cycle();                       // enqueue rd12 and dequeue rd11 together
        alu_valid = 0;
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata, wb_pending} !== {1'b1, 5'd11, d1, 2'd1})
            $display("FAIL stall_write1: got wen=%0b waddr=%0d wdata=%0h pend=%0d expected 1 11 %0h 1",
                     rf_wen, rf_waddr, rf_wdata, wb_pending, d1);
        else n_pass++;
        clk_cycle();
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata, wb_pending} !== {1'b1, 5'd12, d2, 2'd0})
            $display("FAIL stall_write2: got wen=%0b waddr=%0d wdata=%0h pend=%0d expected 1 12 %0h 0",
                     rf_wen, rf_waddr, rf_wdata, wb_pending, d2);
        else n_pass++;
        clk_cycle();
    endtask

    task automatic test_waw();
        idle();
        rs1 = 5'd7;
        issue_valid = 1; issue_rd = 5'd7;
        clk_cycle();
        issue_valid = 0;
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h0000_0077;
        clk_cycle();                       // edge N: result accepted
        alu_valid = 0;
        issue_valid = 1; issue_rd = 5'd7;
        #1;
        n_total++;
        if (issue_ready !== 1'b0) $display("FAIL waw_stall: issue_ready=%0b expected 0", issue_ready);
        else n_pass++;
        clk_cycle();                       // edge N+1
        #1;
        n_total++;
        if ({issue_ready, rf_wen, rf_waddr} !== {1'b0, 1'b1, 5'd7})
            $display("FAIL waw_clearing: got ready=%0b wen=%0b waddr=%0d expected 0 1 7", issue_ready, rf_wen, rf_waddr);
        else n_pass++;
        clk_cycle();                       // edge N+2: busy[7] cleared
        #1;
        n_total++;
        if ({issue_ready, rs1_busy} !== 2'b10)
            $display("FAIL waw_released: got ready=%0b busy=%0b expected 1 0", issue_ready, rs1_busy);
        else n_pass++;
        clk_cycle();
        issue_valid = 0;
        #1;
        n_total++;
        if (rs1_busy !== 1'b1) $display("FAIL waw_reissue: busy=%0b expected 1", rs1_busy);
        else n_pass++;
        // Drain the reservation with a result, then write to x7 unreserved
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h0000_0078;
        clk_cycle();
        alu_valid = 0;
        clk_cycle();
        clk_cycle();
        #1;
        n_total++;
        if (rs1_busy !== 1'b0) $display("FAIL waw_drain: busy=%0b expected 0", rs1_busy);
        else n_pass++;
        alu_valid = 1; alu_rd = 5'd7; alu_data = 32'h0000_0079;
        clk_cycle();
        alu_valid = 0;
        clk_cycle();                       // write port now targets x7
        issue_valid = 1; issue_rd = 5'd7;
        #1;
        n_total++;
        if ({issue_ready, rf_wen, rf_waddr} !== {1'b1, 1'b1, 5'd7})
            $display("FAIL waw_set_ready: got ready=%0b wen=%0b waddr=%0d expected 1 1 7", issue_ready, rf_wen, rf_waddr);
        else n_pass++;
        clk_cycle();                       // set and clear of x7 on one edge
        issue_valid = 0;
        #1;
        n_total++;
        if (rs1_busy !== 1'b1) $display("FAIL waw_set_wins: busy=%0b expected 1", rs1_busy);
        else n_pass++;
    endtask

    task automatic test_rd0();
        idle();
        alu_valid = 1; alu_rd = 5'd0; alu_data = 32'h1234;
        #1;
        n_total++;
        if (alu_ready !== 1'b1) $display("FAIL rd0_ready: alu_ready=%0b expected 1", alu_ready);
        else n_pass++;
        clk_cycle();
        alu_valid = 0;
        #1;
        n_total++;
        if ({wb_pending, rf_wen} !== 3'b000)
            $display("FAIL rd0_discard: got pend=%0d wen=%0b expected 0 0", wb_pending, rf_wen);
        else n_pass++;
        clk_cycle();
        issue_valid = 1; issue_rd = 5'd0; rs1 = 5'd0; rs2 = 5'd7;
        #1;
        n_total++;
        if ({rf_wen, issue_ready} !== 2'b01)
            $display("FAIL rd0_issue: got wen=%0b ready=%0b expected 0 1", rf_wen, issue_ready);
        else n_pass++;
        clk_cycle();
        issue_valid = 0;
        #1;
        n_total++;
        if ({rs1_busy, rs2_busy} !== 2'b01)
            $display("FAIL rd0_busy: got rs1=%0b rs2=%0b expected 0 1", rs1_busy, rs2_busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        idle();
        rs1 = 5'd9;
        issue_valid = 1; issue_rd = 5'd9;
        clk_cycle();
        issue_valid = 0;
        wb_stall = 1;
        alu_valid = 1; alu_rd = 5'd9; alu_data = $urandom;
        clk_cycle();
        alu_rd = 5'd13; alu_data = $urandom;
        clk_cycle();
        alu_valid = 0;
        #1;
        n_total++;
        if ({wb_pending, rs1_busy} !== {2'd2, 1'b1})
            $display("FAIL midrst_setup: got pend=%0d busy=%0b expected 2 1", wb_pending, rs1_busy);
        else n_pass++;
        #1 rst_n = 0;
        model_reset();
        #1;
        n_total++;
        if ({rf_wen, rf_waddr, rf_wdata, wb_pending, rs1_busy} !== '0)
            $display("FAIL midrst_clear: got wen=%0b waddr=%0d wdata=%0h pend=%0d busy=%0b expected all 0",
                     rf_wen, rf_waddr, rf_wdata, wb_pending, rs1_busy);
        else n_pass++;
        wb_stall = 0;
        clk_cycle();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            clk_cycle();
            #1;
            n_total++;
            if ({rf_wen, wb_pending} !== 3'b000)
                $display("FAIL midrst_quiet[%0d]: got wen=%0b pend=%0d expected 0 0", i, rf_wen, wb_pending);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [4:0]    exp_c, got_c;
        logic [RW-1:0] exp_r, got_r;
        bit            full;
        idle();
        for (int i = 0; i < 400; i++) begin
            issue_valid = $urandom_range(0, 1);
            issue_rd    = 5'($urandom_range(0, 7));
            rs1         = 5'($urandom_range(0, 7));
            rs2         = 5'($urandom_range(0, 7));
            alu_valid   = ($urandom_range(0, 2) != 0);
            alu_rd      = 5'($urandom_range(0, 7));
            alu_data    = $urandom;
            lsu_valid   = ($urandom_range(0, 3) == 0);
            lsu_rd      = 5'($urandom_range(0, 7));
            lsu_data    = $urandom;
            wb_stall    = ($urandom_range(0, 3) == 0);
            #1;
            full  = (m_q.size() == 2);
            exp_c = {!full, !full && !lsu_valid, (issue_rd == 0) || !m_busy[issue_rd],
                     m_busy[rs1], m_busy[rs2]};
            got_c = {lsu_ready, alu_ready, issue_ready, rs1_busy, rs2_busy};
            n_total++;
            if (got_c !== exp_c)
                $display("FAIL rand_comb[%0d]: got lsu/alu/issue/rs1/rs2=%b expected %b", i, got_c, exp_c);
            else n_pass++;
            clk_cycle();
            #1;
            exp_r = {m_wen, m_waddr, m_wdata, 2'(m_q.size())};
            got_r = {rf_wen, rf_waddr, rf_wdata, wb_pending};
            n_total++;
            if (got_r !== exp_r)
                $display("FAIL rand_wb[%0d]: got wen/waddr/wdata/pend=%h expected %h", i, got_r, exp_r);
            else n_pass++;
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_priority();
        test_stall();
        test_waw();
        test_rd0();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 Parameter: XLEN, 32, data width of results and regfile write data.
REQ-002 Port: clk  in  1  single clock; all state updates on posedge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: issue_valid  in  1  decoder requests reservation of issue_rd.
REQ-005 Port: issue_rd  in  5  destination register being issued.
REQ-006 Port: issue_ready  out  1  reservation accepted this cycle.
REQ-007 Port: rs1 / rs2  in  5 each  source register hazard queries.
REQ-008 Port: rs1_busy / rs2_busy  out  1 each  queried register has a pending write.
REQ-009 Port: alu_valid, alu_rd[5], alu_data[XLEN]  in  ALU result offer.
REQ-010 Port: alu_ready  out  1  ALU result accepted.
REQ-011 Port: lsu_valid, lsu_rd[5], lsu_data[XLEN]  in  LSU result offer.
REQ-012 Port: lsu_ready  out  1  LSU result accepted.
REQ-013 Port: wb_stall  in  1  freeze regfile writes (debug/difftest hold).
REQ-014 Port: rf_wen, rf_waddr[5], rf_wdata[XLEN]  out  regfile write port, all registered.
REQ-015 Port: wb_pending  out  2  FIFO occupancy, 0..2.

Function
REQ-016 Scoreboard busy[31:0] SHALL be registered; busy[0] SHALL be constant 0.
REQ-017 rsN_busy SHALL equal busy[rsN] combinationally; no bypass from FIFO or rf_* regs.
REQ-018 issue_ready SHALL be 1 when issue_rd==0 or busy[issue_rd]==0; else 0 (WAW stall).
REQ-019 issue_valid & issue_ready & issue_rd!=0 SHALL set busy[issue_rd] at the next edge.
REQ-020 rf_wen==1 at an edge SHALL clear busy[rf_waddr] at that edge.
REQ-021 Set and clear of the same index at one edge: set SHALL win.
REQ-022 Result FIFO: 2 entries of {rd, data}; one enqueue and one dequeue max per cycle.
REQ-023 lsu_ready SHALL be ~full; alu_ready SHALL be ~full & ~lsu_valid (LSU fixed priority).
REQ-024 ready SHALL depend on full only; no enqueue while full even if a dequeue occurs that cycle.
REQ-025 Handshake: transfer occurs when valid & ready at an edge; offered fields SHALL be ignored otherwise.
REQ-026 An accepted result with rd==0 SHALL be discarded (not enqueued); handshake still completes.
REQ-027 FIFO order SHALL be strict acceptance order.
REQ-028 Dequeue SHALL occur at an edge when FIFO non-empty and wb_stall==0; that edge loads rf_wen=1, rf_waddr, rf_wdata.
REQ-029 At an edge with no dequeue, rf_wen SHALL load 0 and rf_waddr/rf_wdata SHALL hold.
REQ-030 Latency: result accepted at edge N, FIFO otherwise empty, wb_stall=0 -> rf_wen high during cycle after N+1, regfile written and busy cleared at edge N+2.
REQ-031 Simultaneous enqueue and dequeue with 1 entry: occupancy stays 1, order preserved.
REQ-032 Pointers SHALL wrap modulo 2; wb_pending SHALL equal occupancy each cycle.
REQ-033 wb_stall SHALL not affect ready, enqueue or issue reservation.

Reset
REQ-034 rst_n low SHALL immediately clear busy, empty the FIFO (wb_pending=0), and set rf_wen=0, rf_waddr=0, rf_wdata=0, independent of clk.
REQ-035 Reset mid-operation SHALL discard all buffered results and reservations; no rf_wen pulse after release until a new result is accepted.
REQ-036 During reset alu_ready/lsu_ready SHALL read 1 (FIFO empty) but no transfer SHALL be recorded.

Verification
REQ-037 Issue rd=5, then ALU {rd=5, 0xDEADBEEF} accepted at edge N -> rs1=5 busy until edge N+2; rf_wen=1, rf_waddr=5, rf_wdata=0xDEADBEEF in cycle N+1..N+2.
REQ-038 alu_valid and lsu_valid same cycle (rd=3/0x11, rd=4/0x22), FIFO empty -> lsu accepted first, alu_ready=0; next cycle ALU accepted; writes appear rd=4 then rd=3.
REQ-039 wb_stall=1, three results offered -> two accepted, wb_pending=2, third sees ready=0; release stall -> two writes on consecutive cycles in order, then third accepted.
REQ-040 Issue rd=7 while busy[7]=1 -> issue_ready=0; same edge rf_wen clears 7 -> issue_ready=1 next cycle; issue at a clearing edge leaves busy[7]=1.
REQ-041 Result rd=0 data 0x1234 -> accepted, wb_pending stays 0, no rf_wen; issue rd=0 -> issue_ready=1, busy unchanged.
REQ-042 Assert rst_n=0 mid-cycle with 2 entries pending and busy[9]=1 -> rf_wen, wb_pending, busy all 0 immediately; no writes after release.
